hps_cmd_queue: RTL and testbench

- Parametrised command front-end between the HPS PIO bank and the image coprocessor.
- Replaces the direct start/done wiring: each rising edge of the HPS start PIO snapshots all NUM_CH command PIO words (instruct, window dim, window pos, ...) into a FIFO.
- Dispatches queued commands to the coprocessor over a valid/ready handshake, tracks completion with a timeout, and reports done/status words back to HPS PIOs.

---
 rtl/hps_cmd_pkg.sv | 9 +
 rtl/hps_cmd_fifo.sv | 43 ++++
 rtl/hps_cmd_queue.sv | 126 ++++++++++++
 tb/tb_hps_cmd_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hps_cmd_pkg.sv
// hps_cmd_pkg: shared FSM state type and status word bit positions
package hps_cmd_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_OCC_LSB = 16;
    localparam int STAT_OVF     = 24;
    localparam int STAT_TMO     = 25;
    localparam int STAT_BUSY    = 26;
endpackage

// File: rtl/hps_cmd_fifo.sv
// hps_cmd_fifo: show-ahead synchronous FIFO with occupancy count and sync clear
module hps_cmd_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 8
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    // storage array; a push into a full FIFO is only issued alongside a pop,
    // so overwriting the slot under the read pointer is safe
    always_ff @(posedge clk_clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    // pointers and occupancy, cleared by reset or the soft clear
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
endmodule

// File: rtl/hps_cmd_queue.sv
// hps_cmd_queue: queues HPS PIO commands and dispatches them to the coprocessor
module hps_cmd_queue
    import hps_cmd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 3,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic                     soft_rst,
    input  logic                     start,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     cmd_valid,
    output logic [NUM_CH*DATA_W-1:0] cmd_data,
    input  logic                     cmd_ready,
    input  logic                     op_done,
    output logic                     done,
    output logic [31:0]              status
);
    localparam int W  = NUM_CH * DATA_W;
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_start_q;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [15:0]   r_cnt;
    logic [15:0]   w_cnt_nxt;
    logic          r_ovf;
    logic          w_ovf_nxt;
    logic          r_tmo;
    logic          w_tmo_nxt;
    logic          r_done;
    logic [31:0]   r_status;
    logic [31:0]   w_status;
    logic          w_push;
    logic          w_push_acc;
    logic          w_pop;
    logic [AW:0]   w_occ;
    logic [AW:0]   w_occ_nxt;
    logic [W-1:0]  w_head;

    hps_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .i_clr         (soft_rst),
        .i_push        (w_push_acc),
        .i_pop         (w_pop),
        .i_data        (ch_data),
        .o_head        (w_head),
        .o_count       (w_occ)
    );

    // queue handshakes, next-state logic and the next status word; soft_rst overrides all
    always_comb begin
        w_pop       = (r_state == ISSUE) && cmd_ready && !soft_rst;
        w_push      = start && !r_start_q && !soft_rst;
        w_push_acc  = w_push && ((w_occ < (AW+1)'(DEPTH)) || w_pop);
        w_occ_nxt   = soft_rst ? '0 : w_occ + {{AW{1'b0}}, w_push_acc} - {{AW{1'b0}}, w_pop};
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf || (w_push && !w_push_acc);
        w_tmo_nxt   = r_tmo;
        if (soft_rst) begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_tmo_nxt   = 1'b0;
        end else if (r_state == IDLE) begin
            if (w_occ != '0) w_state_nxt = ISSUE;
        end else if (r_state == ISSUE) begin
            if (cmd_ready) begin
                w_state_nxt = BUSY;
                w_timer_nxt = '0;
            end
        end else if (op_done) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = r_cnt + 16'd1;
        end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
            w_state_nxt = IDLE;
            w_tmo_nxt   = 1'b1;
        end else begin
            w_timer_nxt = r_timer + 1'b1;
        end
        w_status                       = '0;
        w_status[STAT_CNT_LSB +: 16]   = w_cnt_nxt;
        w_status[STAT_OCC_LSB +: 8]    = 8'(w_occ_nxt);
        w_status[STAT_OVF]             = w_ovf_nxt;
        w_status[STAT_TMO]             = w_tmo_nxt;
        w_status[STAT_BUSY]            = (w_state_nxt == BUSY);
    end

    // state, counters, edge detect and registered outputs
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state   <= IDLE;
            r_start_q <= 1'b1;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_tmo     <= 1'b0;
            r_done    <= 1'b1;
            r_status  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start;
            r_timer   <= w_timer_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovf     <= w_ovf_nxt;
            r_tmo     <= w_tmo_nxt;
            r_done    <= (w_state_nxt == IDLE) && (w_occ_nxt == '0);
            r_status  <= w_status;
        end
    end

    assign cmd_valid = (r_state == ISSUE);
    assign cmd_data  = w_head;
    assign done      = r_done;
    assign status    = r_status;
endmodule

// File: tb/tb_hps_cmd_queue.sv
// tb_hps_cmd_queue: directed self-checking bench for hps_cmd_queue
module tb_hps_cmd_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        soft_rst;
    logic        start;
    logic [95:0] ch_data;
    logic        cmd_valid;
    logic [95:0] cmd_data;
    logic        cmd_ready;
    logic        op_done;
    logic        done;
    logic [31:0] status;
    int          total = 0;
    int          bad = 0;

    hps_cmd_queue #(.DATA_W(32), .NUM_CH(3), .DEPTH(8), .TIMEOUT_CYC(16)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .soft_rst      (soft_rst),
        .start         (start),
        .ch_data       (ch_data),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .op_done       (op_done),
        .done          (done),
        .status        (status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [95:0] d);
        ch_data = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic serve(input string tag, input logic [95:0] d);
        chk({tag, "_valid"}, 96'(cmd_valid), 96'd1);
        chk({tag, "_data"}, cmd_data, d);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk({tag, "_busy"}, 96'(status[26]), 96'd1);
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; soft_rst = 1'b0; start = 1'b0; ch_data = '0; cmd_ready = 1'b0; op_done = 1'b0;
        tick(); tick();
        chk("rst_valid", 96'(cmd_valid), 96'd0);
        chk("rst_done", 96'(done), 96'd1);
        chk("rst_status", 96'(status), 96'd0);
        rst_n = 1'b1;
        tick();
        // single command
        ch_data = {32'h3, 32'h00200020, 32'h00100010};
        cmd_ready = 1'b1;
        start = 1'b1;
        tick();
        chk("single_c1_valid", 96'(cmd_valid), 96'd0);
        chk("single_c1_done", 96'(done), 96'd0);
        chk("single_c1_status", 96'(status), 96'h0001_0000);
        tick();
        chk("single_c2_valid", 96'(cmd_valid), 96'd1);
        chk("single_c2_data", cmd_data, {32'h3, 32'h00200020, 32'h00100010});
        start = 1'b0;
        tick();
        cmd_ready = 1'b0;
        chk("single_busy", 96'(status), 96'h0400_0000);
        repeat (4) tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("single_status", 96'(status), 96'h0000_0001);
        chk("single_done", 96'(done), 96'd1);
        // fill and overflow
        for (int i = 1; i <= 9; i++) pulse({3{32'(i)}});
        chk("fill_status", 96'(status), 96'h0108_0001);
        chk("fill_done", 96'(done), 96'd0);
        for (int k = 1; k <= 8; k++) serve("drain", {3{32'(k)}});
        chk("drain_valid", 96'(cmd_valid), 96'd0);
        chk("drain_status", 96'(status), 96'h0100_0009);
        chk("drain_done", 96'(done), 96'd1);
        // same-cycle push and pop on a full queue
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("srst1_status", 96'(status), 96'd0);
        for (int i = 1; i <= 8; i++) pulse({3{32'h10 + 32'(i)}});
        chk("full_status", 96'(status), 96'h0008_0000);
        ch_data = {3{32'hAA}};
        start = 1'b1;
        cmd_ready = 1'b1;
        tick();
        start = 1'b0;
        cmd_ready = 1'b0;
        chk("pushpop_status", 96'(status), 96'h0408_0000);
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        tick();
        for (int k = 2; k <= 8; k++) serve("pp_drain", {3{32'h10 + 32'(k)}});
        serve("pp_tail", {3{32'hAA}});
        chk("pp_status", 96'(status), 96'h0000_0009);
        chk("pp_done", 96'(done), 96'd1);
        // timeout
        pulse({3{32'h44}});
        chk("tmo_valid", 96'(cmd_valid), 96'd1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        repeat (15) tick();
        chk("tmo_still_busy", 96'(status), 96'h0400_0009);
        tick();
        chk("tmo_exit", 96'(status), 96'h0200_0009);
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        tick();
        chk("tmo_late_done", 96'(status), 96'h0200_0009);
        chk("tmo_done", 96'(done), 96'd1);
        // soft reset mid-operation
        for (int i = 1; i <= 4; i++) pulse({3{32'h50 + 32'(i)}});
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("sr_busy", 96'(status), 96'h0603_0009);
        start = 1'b1;
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("sr_status", 96'(status), 96'd0);
        chk("sr_done", 96'(done), 96'd1);
        chk("sr_valid", 96'(cmd_valid), 96'd0);
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("sr_opdone_ignored", 96'(status), 96'd0);
        tick(); tick();
        chk("sr_start_held", 96'(status), 96'd0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("sr_repush", 96'(status), 96'h0001_0000);
        chk("sr_repush_done", 96'(done), 96'd0);
        tick();
        chk("sr_repush_valid", 96'(cmd_valid), 96'd1);
        // reset with start held high
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("hr_status", 96'(status), 96'd0);
        chk("hr_done", 96'(done), 96'd1);
        chk("hr_valid", 96'(cmd_valid), 96'd0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("hr_one_push", 96'(status), 96'h0001_0000);
        tick(); tick();
        chk("hr_one_only", 96'(status), 96'h0001_0000);
        chk("hr_valid2", 96'(cmd_valid), 96'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
